// File: rtl/button_event_port.sv
// Front-panel button responder for the PicoBlaze input ports: synchronizes and debounces
// five buttons, latches press events into sticky flags and serves them with clear-on-read.
module button_event_port #(
    parameter int         DEBOUNCE_CYCLES = 1000000,
    parameter logic [7:0] EVENT_PORT      = 8'h0B,
    parameter logic [7:0] LEVEL_PORT      = 8'h0C
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] btn_in,
    input  logic [7:0] port_id,
    input  logic       read_strobe,
    output logic [7:0] data_out,
    output logic [4:0] btn_level,
    output logic       event_pending
);

    localparam int               CNT_W   = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [4:0]       r_sync1;
    logic [4:0]       r_sync2;
    logic [4:0]       r_level;
    logic [CNT_W-1:0] r_cnt [5];
    logic [4:0]       r_evt;
    logic             r_ovr;
    logic             r_pend;
    logic [7:0]       r_data;

    logic [4:0]       w_accept;
    logic [4:0]       w_press;
    logic             w_evt_read;
    logic [4:0]       w_clr_evt;
    logic             w_clr_ovr;
    logic [4:0]       w_evt_kept;
    logic [4:0]       w_evt_next;
    logic             w_ovr_hit;

    function automatic logic [7:0] read_mux(
        input logic [7:0] pid,
        input logic       ovr,
        input logic [4:0] evt,
        input logic [4:0] lvl
    );
        logic [7:0] v;
        v = 8'h00;
        if (pid == EVENT_PORT)
            v = {ovr, 2'b00, evt};
        else if (pid == LEVEL_PORT)
            v = {3'b000, lvl};
        return v;
    endfunction

    // Two-flop synchronizer followed by a per-button stability counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_level <= '0;
            for (int i = 0; i < 5; i++)
                r_cnt[i] <= '0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 5; i++) begin
                if (r_sync2[i] == r_level[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_cnt[i]   <= '0;
                    r_level[i] <= r_sync2[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 5; i++)
            w_accept[i] = (r_sync2[i] != r_level[i]) && (r_cnt[i] == CNT_MAX);
    end

    // The clear mask is the registered snapshot the CPU is sampling, never the live flags.
    assign w_press    = w_accept & r_sync2;
    assign w_evt_read = read_strobe && (port_id == EVENT_PORT);
    assign w_clr_evt  = w_evt_read ? r_data[4:0] : 5'b00000;
    assign w_clr_ovr  = w_evt_read & r_data[7];
    assign w_evt_kept = r_evt & ~w_clr_evt;
    assign w_evt_next = w_evt_kept | w_press;
    assign w_ovr_hit  = |(w_press & w_evt_kept);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_evt  <= '0;
            r_ovr  <= 1'b0;
            r_pend <= 1'b0;
            r_data <= '0;
        end else begin
            r_evt  <= w_evt_next;
            r_ovr  <= (r_ovr & ~w_clr_ovr) | w_ovr_hit;
            r_pend <= |w_evt_next;
            r_data <= read_mux(port_id, r_ovr, r_evt, r_level);
        end
    end

    assign data_out      = r_data;
    assign btn_level     = r_level;
    assign event_pending = r_pend;

endmodule

// File: tb/tb_button_event_port.sv
// Bench for button_event_port: vector table, directed corner sequences and a randomized
// run, all compared every cycle against a behavioural model of the button rules.
module tb_button_event_port;

    localparam int         D   = 4;
    localparam logic [7:0] EVP = 8'h0B;
    localparam logic [7:0] LVP = 8'h0C;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] btn_in;
    logic [7:0] port_id;
    logic       read_strobe;
    logic [7:0] data_out;
    logic [4:0] btn_level;
    logic       event_pending;

    always #5 clk = ~clk;

    button_event_port #(
        .DEBOUNCE_CYCLES(D),
        .EVENT_PORT     (EVP),
        .LEVEL_PORT     (LVP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_in       (btn_in),
        .port_id      (port_id),
        .read_strobe  (read_strobe),
        .data_out     (data_out),
        .btn_level    (btn_level),
        .event_pending(event_pending)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: a 2-sample delay line, the last D synchronized samples, and flags.
    logic [4:0] m_line [$];
    logic [4:0] m_hist [$];
    logic [4:0] m_level = '0;
    logic [4:0] m_evt   = '0;
    logic       m_ovr   = 1'b0;
    logic       m_pend  = 1'b0;
    logic [7:0] m_dout  = '0;

    typedef struct {
        logic [4:0] btn;
        logic [7:0] port;
        logic       strb;
        int         cyc;
        logic [4:0] lev;
        logic [7:0] dout;
        logic       pend;
    } vec_t;

    vec_t tbl [16];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [4:0] sync, nlev, press, keep;
        logic [7:0] clr, nd;
        logic       differs;
        if (reset) begin
            m_line.delete();
            m_line.push_back(5'd0);
            m_line.push_back(5'd0);
            m_hist.delete();
            m_level = '0;
            m_evt   = '0;
            m_ovr   = 1'b0;
            m_pend  = 1'b0;
            m_dout  = '0;
            return;
        end
        sync = m_line.pop_front();
        m_line.push_back(btn_in);
        m_hist.push_back(sync);
        if (m_hist.size() > D)
            void'(m_hist.pop_front());
        nlev = m_level;
        if (m_hist.size() == D) begin
            for (int i = 0; i < 5; i++) begin
                differs = 1'b1;
                foreach (m_hist[k])
                    if (m_hist[k][i] == m_level[i])
                        differs = 1'b0;
                if (differs)
                    nlev[i] = sync[i];
            end
        end
        press = nlev & ~m_level;
        clr   = (read_strobe && port_id == EVP) ? m_dout : 8'h00;
        if (port_id == EVP)
            nd = {m_ovr, 2'b00, m_evt};
        else if (port_id == LVP)
            nd = {3'b000, m_level};
        else
            nd = 8'h00;
        keep    = m_evt & ~clr[4:0];
        m_ovr   = (m_ovr & ~clr[7]) | (|(press & keep));
        m_evt   = keep | press;
        m_pend  = |m_evt;
        m_level = nlev;
        m_dout  = nd;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check8("model_data_out", data_out, m_dout);
        check8("model_btn_level", {3'b000, btn_level}, {3'b000, m_level});
        check8("model_event_pending", {7'd0, event_pending}, {7'd0, m_pend});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [7:0] dout,
                              input logic [4:0] lev, input logic pend);
        check8({name, "_data_out"}, data_out, dout);
        check8({name, "_btn_level"}, {3'b000, btn_level}, {3'b000, lev});
        check8({name, "_event_pending"}, {7'd0, event_pending}, {7'd0, pend});
    endtask

    initial begin
        int bit_idx, sel;

        tbl[0]  = '{5'b00010, 8'h0B, 1'b0, 5, 5'b00000, 8'h00, 1'b0};
        tbl[1]  = '{5'b00010, 8'h0B, 1'b0, 1, 5'b00010, 8'h00, 1'b1};
        tbl[2]  = '{5'b00010, 8'h0B, 1'b0, 1, 5'b00010, 8'h02, 1'b1};
        tbl[3]  = '{5'b00010, 8'h0C, 1'b0, 1, 5'b00010, 8'h02, 1'b1};
        tbl[4]  = '{5'b00010, 8'h0B, 1'b0, 1, 5'b00010, 8'h02, 1'b1};
        tbl[5]  = '{5'b00010, 8'h0B, 1'b1, 1, 5'b00010, 8'h02, 1'b0};
        tbl[6]  = '{5'b00010, 8'h0B, 1'b0, 1, 5'b00010, 8'h00, 1'b0};
        tbl[7]  = '{5'b00010, 8'h0C, 1'b1, 1, 5'b00010, 8'h02, 1'b0};
        tbl[8]  = '{5'b01010, 8'h0B, 1'b0, 6, 5'b01010, 8'h00, 1'b1};
        tbl[9]  = '{5'b00010, 8'h0B, 1'b0, 6, 5'b00010, 8'h08, 1'b1};
        tbl[10] = '{5'b01010, 8'h0B, 1'b0, 6, 5'b01010, 8'h08, 1'b1};
        tbl[11] = '{5'b01010, 8'h0B, 1'b0, 1, 5'b01010, 8'h88, 1'b1};
        tbl[12] = '{5'b01010, 8'h0B, 1'b1, 1, 5'b01010, 8'h88, 1'b0};
        tbl[13] = '{5'b01010, 8'h0B, 1'b0, 1, 5'b01010, 8'h00, 1'b0};
        tbl[14] = '{5'b01010, 8'h55, 1'b0, 1, 5'b01010, 8'h00, 1'b0};
        tbl[15] = '{5'b01010, 8'h0C, 1'b0, 1, 5'b01010, 8'h0A, 1'b0};

        btn_in      = '0;
        port_id     = '0;
        read_strobe = 1'b0;
        do_reset();
        expect_out("reset", 8'h00, 5'b00000, 1'b0);

        for (int i = 0; i < 16; i++) begin
            btn_in      = tbl[i].btn;
            port_id     = tbl[i].port;
            read_strobe = tbl[i].strb;
            repeat (tbl[i].cyc) tick();
            expect_out($sformatf("vec%0d", i), tbl[i].dout, tbl[i].lev, tbl[i].pend);
        end
        read_strobe = 1'b0;

        btn_in = '0;
        do_reset();
        port_id = EVP;
        btn_in  = 5'b00001;
        repeat (3) tick();
        btn_in = 5'b00000;
        repeat (10) tick();
        expect_out("glitch", 8'h00, 5'b00000, 1'b0);

        do_reset();
        port_id = EVP;
        btn_in  = 5'b00100;
        repeat (6) tick();
        expect_out("sd_press1", 8'h00, 5'b00100, 1'b1);
        btn_in = 5'b00000;
        repeat (6) tick();
        expect_out("sd_release", 8'h04, 5'b00000, 1'b1);
        btn_in = 5'b00100;
        repeat (5) tick();
        read_strobe = 1'b1;
        tick();
        read_strobe = 1'b0;
        expect_out("set_wins", 8'h04, 5'b00100, 1'b1);
        tick();
        expect_out("set_wins_next", 8'h04, 5'b00100, 1'b1);
        read_strobe = 1'b1;
        tick();
        read_strobe = 1'b0;
        tick();
        expect_out("set_wins_cleared", 8'h00, 5'b00100, 1'b0);

        btn_in = '0;
        do_reset();
        port_id = EVP;
        btn_in  = 5'b10000;
        repeat (3) tick();
        do_reset();
        expect_out("mid_reset", 8'h00, 5'b00000, 1'b0);
        repeat (5) tick();
        expect_out("held_wait", 8'h00, 5'b00000, 1'b0);
        tick();
        expect_out("held_accept", 8'h00, 5'b10000, 1'b1);
        tick();
        expect_out("held_event", 8'h10, 5'b10000, 1'b1);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                bit_idx = int'($urandom_range(0, 4));
                btn_in[bit_idx] = ~btn_in[bit_idx];
            end
            sel = int'($urandom_range(0, 3));
            if (sel == 1)
                port_id = LVP;
            else if (sel == 3)
                port_id = 8'($urandom_range(0, 255));
            else
                port_id = EVP;
            read_strobe = ($urandom_range(0, 3) == 0);
            reset       = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
